// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
// Shared definitions for the bit-serial adder controller: the controller state
// type and the default operand width.
package serial_adder_pkg;

  // Default operand / sum width in bits (legal range: 2 or more).
  localparam int unsigned WidthDefault = 8;

  // Controller states, 2-bit encoding.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_t;

endpackage

// File: rtl/full_adder.sv
// full_adder
// One-bit full adder, purely combinational.
// Ports:
//   a, b  : addend bits
//   ci    : carry in
//   sum   : a ^ b ^ ci
//   carry : carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum,
  output logic carry
);

  logic w_prop;

  assign w_prop = a ^ b;
  assign sum    = w_prop ^ ci;
  assign carry  = (a & b) | (ci & w_prop);

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
// Bit-serial adder: pushes WIDTH-bit operands through a single full_adder one
// bit per clock, LSB first. Operands are latched on an accepted start, the
// running carry lives in a flop between steps, and the finished sum/carry-out
// are presented with a one-cycle done pulse. Latency is WIDTH+1 cycles.
// Optional feature macro: SERIAL_ADD_OVF_EN adds the signed-overflow output ovf.
// Ports:
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset
//   start   : request, sampled only in idle or done
//   a_in    : operand A, latched on accepted start
//   b_in    : operand B, latched on accepted start
//   cin     : carry in, latched on accepted start
//   busy    : high while bit steps are running
//   done    : one-cycle completion pulse
//   sum_out : result, held until the next completion
//   cout    : final carry-out, held like sum_out
//   ovf     : signed overflow (SERIAL_ADD_OVF_EN only)
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = WidthDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  // Holds the WIDTH-1 sum bits produced so far; newest bit at the MSB.
  logic [WIDTH-2:0] r_sum_sh;
  logic             r_carry;
  logic [CntW-1:0]  r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum_out;
  logic             r_cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             r_ovf;
`endif

  logic             w_sum;
  logic             w_carry;
  logic [WIDTH-1:0] w_sum_cat;

  full_adder u_full_adder (
    .a     (r_a_sh[0]),
    .b     (r_b_sh[0]),
    .ci    (r_carry),
    .sum   (w_sum),
    .carry (w_carry)
  );

  // On the last step this is the complete result; earlier its top WIDTH-1 bits
  // are the next contents of the sum shift register.
  assign w_sum_cat = {w_sum, r_sum_sh};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_sum_sh  <= '0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sum_out <= '0;
      r_cout    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      r_ovf     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle, StDone: begin
          if (start) begin
            r_a_sh  <= a_in;
            r_b_sh  <= b_in;
            r_carry <= cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= StRun;
          end else begin
            r_state <= StIdle;
          end
        end
        StRun: begin
          r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_sum_sh <= w_sum_cat[WIDTH-1:1];
          r_carry  <= w_carry;
          if (r_cnt == LastCnt) begin
            r_sum_out <= w_sum_cat;
            r_cout    <= w_carry;
`ifdef SERIAL_ADD_OVF_EN
            // Carry into the MSB step is still in r_carry here.
            r_ovf     <= r_carry ^ w_carry;
`endif
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= StDone;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign sum_out = r_sum_out;
  assign cout    = r_cout;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf     = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8). Expected results come
// from plain integer addition; timing is checked cycle by cycle.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum_out;
  logic         cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int n_chk;
  int n_err;

  // Last completed result, expected to be held on the outputs.
  logic [W-1:0] prev_sum;
  logic         prev_cout;
  logic         prev_ovf;

  serial_adder_ctrl #(
    .WIDTH (W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .cin     (cin),
    .busy    (busy),
    .done    (done),
    .sum_out (sum_out),
    .cout    (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf     (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_held(input string tag);
    check({tag, "_sum_held"}, 32'(sum_out), 32'(prev_sum));
    check({tag, "_cout_held"}, 32'(cout), 32'(prev_cout));
`ifdef SERIAL_ADD_OVF_EN
    check({tag, "_ovf_held"}, 32'(ovf), 32'(prev_ovf));
`endif
  endtask

  // Called at a negedge; raises start in this cycle and follows the operation
  // to its done cycle, returning at the negedge of that cycle with start low.
  // ign_at > 0 pulses a stray start with different operands in that RUN cycle.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input int ign_at);
    logic [W:0] full;
    logic       exp_ovf;
    bit         got_done;
    full     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    exp_ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    a_in     = a;
    b_in     = b;
    cin      = ci;
    start    = 1'b1;
    got_done = 1'b0;
    for (int n = 1; n <= int'(W) + 4 && !got_done; n++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (n == ign_at) begin
        start = 1'b1;
        a_in  = 8'hFF;
        b_in  = 8'hFF;
        cin   = 1'b1;
      end
      check({tag, "_overlap"}, 32'(busy & done), 32'd0);
      if (done) begin
        got_done = 1'b1;
        check({tag, "_latency"}, 32'(n), W + 1);
        check({tag, "_sum"}, 32'(sum_out), 32'(full[W-1:0]));
        check({tag, "_cout"}, 32'(cout), 32'(full[W]));
`ifdef SERIAL_ADD_OVF_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`endif
        prev_sum  = full[W-1:0];
        prev_cout = full[W];
        prev_ovf  = exp_ovf;
      end else if (n <= int'(W)) begin
        check({tag, "_busy"}, 32'(busy), 32'd1);
        if (n == 2) check_held(tag);
      end
    end
    if (!got_done) check({tag, "_timeout"}, 32'd0, 32'd1);
    start = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    n_chk     = 0;
    n_err     = 0;
    prev_sum  = '0;
    prev_cout = 1'b0;
    prev_ovf  = 1'b0;
    rst       = 1'b1;
    start     = 1'b0;
    a_in      = '0;
    b_in      = '0;
    cin       = 1'b0;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check_held("rst");
    rst = 1'b0;
    idle(2);
    check("idle_busy", 32'(busy), 32'd0);

    // Directed cases.
    do_op("d0F_01", 8'h0F, 8'h01, 1'b0, 0);
    idle(1);
    check("after_done_low", 32'(done), 32'd0);
    do_op("dFF_01", 8'hFF, 8'h01, 1'b0, 0);
    idle(2);
    do_op("dAA_55", 8'hAA, 8'h55, 1'b1, 0);
    idle(1);
    do_op("d7F_01", 8'h7F, 8'h01, 1'b0, 0);
    idle(1);
    do_op("d80_80", 8'h80, 8'h80, 1'b0, 0);
    idle(1);

    // Stray start in RUN is neither queued nor re-latched.
    do_op("ign", 8'h12, 8'h34, 1'b0, 3);
    idle(2);
    check("ign_not_queued", 32'(busy), 32'd0);

    // Reset in the middle of a run.
    a_in  = 8'h55;
    b_in  = 8'h22;
    cin   = 1'b0;
    start = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_sum", 32'(sum_out), 32'd0);
    check("mid_rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    check("mid_rst_ovf", 32'(ovf), 32'd0);
`endif
    prev_sum  = '0;
    prev_cout = 1'b0;
    prev_ovf  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < int'(W) + 3; n++) begin
      @(posedge clk);
      @(negedge clk);
      check("post_rst_no_done", 32'(done | busy), 32'd0);
    end
    do_op("d01_01", 8'h01, 8'h01, 1'b0, 0);

    // Back-to-back: second start issued in the first DONE cycle.
    idle(1);
    do_op("b2b_a", 8'h3C, 8'hC4, 1'b1, 0);
    do_op("b2b_b", 8'h99, 8'h11, 1'b0, 0);
    do_op("b2b_c", 8'hF0, 8'h0F, 1'b1, 0);

    // Randomized operations, some back-to-back, some with idle gaps.
    for (int k = 0; k < 24; k++) begin
      do_op("rnd", 8'($urandom), 8'($urandom), 1'($urandom), 0);
      idle(int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Safety net against a hang anywhere in the sequence.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
    $fatal(1, "watchdog");
  end

endmodule
